memory_port_arbiter: RTL and testbench
======================================

// Module: memory_port_arbiter
// PURPOSE
// - Shares one single-ported unified memory between the Fetch path (instruction reads) and the Memory stage (loads/stores).
// - Sits between Fetch/Memory and the memory macro, replacing the split Imem/Dmem ports.
// - One transaction outstanding at a time; data side has priority, with a bounded-starvation guarantee for fetch.
// PARAMETERS
// - ADDR_WIDTH       32  byte-address width on all ports
// - MAX_DATA_STREAK  4   consecutive data grants allowed while fetch waits; then fetch is forced (1..15)
// PORTS
// - clock              in   1   sole clock, rising edge
// - reset              in   1   synchronous, active-low
// - fetchRequest       in   1   fetch read request; held with fetchAddress until fetchDataValid or fetchFlush
// - fetchAddress       in   32  word-aligned instruction address
// - fetchFlush         in   1   pipeline redirect/trap: squash pending or in-flight fetch
// - fetchData          out  32  instruction word, valid with fetchDataValid
// - fetchDataValid     out  1   one-cycle response pulse
// - dataRequest        in   1   load/store request; held with payload until loadDataValid/storeComplete
// - dataWrite          in   1   1=store, 0=load
// - dataAddress        in   32  byte address
// - dataStoreData      in   32  store data, lane-aligned
// - dataByteEnable     in   4   store byte lanes
// - loadData           out  32  load word, valid with loadDataValid
// - loadDataValid      out  1   one-cycle load response pulse
// - storeComplete      out  1   one-cycle store completion pulse
// - memRequest         out  1   request to memory; held until memReady
// - memWrite           out  1   1=write
// - memAddress         out  32  address to memory
// - memWriteData       out  32  write data
// - memByteEnable      out  4   write lanes (4'b0000 on reads)
// - memReady           in   1   memory accepts the request this cycle; a write also completes
// - memReadValid       in   1   read data return, >=1 cycle after acceptance
// - memReadData        in   32  read data
// BEHAVIOUR
// - Reset (reset==0 at an edge): state IDLE, streak=0, every output 0. This also aborts any in-flight transaction; memReadValid is ignored in IDLE.
// - States:
//   - IDLE: arbitrate among requests present this cycle.
//   - ISSUE_F / ISSUE_D: memRequest=1, payload registered; leave on memReady.
//   - WAIT_F / WAIT_D: awaiting memReadValid.
// - Arbitration in IDLE:
//   - Data only -> ISSUE_D. Fetch only -> ISSUE_F (fetchFlush low).
//   - Both: data wins unless streak==MAX_DATA_STREAK, in which case fetch wins.
//   - Streak: +1 on each data grant while fetchRequest is high; cleared on any fetch grant or when fetchRequest is low at a data grant.
// - Timing: grant decided at edge N; memRequest and payload registered, visible from cycle N+1. No combinational path from request inputs to mem* outputs.
// - ISSUE_D with dataWrite: on memReady pulse storeComplete next cycle, -> IDLE. A read goes to WAIT_D.
// - WAIT_D: on memReadValid register memReadData -> loadData and pulse loadDataValid next cycle, -> IDLE.
// - ISSUE_F -> WAIT_F on memReady. WAIT_F: on memReadValid pulse fetchDataValid with fetchData next cycle, -> IDLE.
// - fetchFlush:
//   - In IDLE: blocks any fetch grant that cycle.
//   - In ISSUE_F: keep memRequest until memReady (no retraction of an issued request); mark the transaction squashed.
//   - In WAIT_F: mark squashed.
//   - A squashed return consumes memReadValid, produces no fetchDataValid, and returns to IDLE.
// - Best-case latency: request at edge 0 -> memRequest cycle 1 -> memReady/memReadValid in cycle 1/2 -> response pulse cycle 3. Store: storeComplete cycle 2.
// - Response pulses are mutually exclusive, at most one per cycle, and never in the cycle a new grant issues.
// - Payload registered at grant; later requester changes are ignored until the response.
// - A response from memory in an unexpected state (memReadValid in IDLE/ISSUE_x) is dropped.
// CONFIGURATION
// - ARB_PERF_COUNTERS_EN defined: adds outputs perfFetchGrants[31:0], perfDataGrants[31:0], perfConflictCycles[31:0].
//   - Conflict cycle = IDLE cycle with both requests high.
//   - Counters wrap at 2^32 and clear on reset.
// - ARB_PERF_COUNTERS_EN undefined: those ports and the counter logic are absent; all other behaviour is identical.
// TESTING
// - Lone fetch 0x100, memReady=1 immediately, memReadValid 1 cycle later with 0x00000013 -> memRequest cycle 1, fetchDataValid+fetchData=0x00000013 cycle 3.
// - Store to 0x2004, BE=4'b0011, data 0xDEADBEEF, memReady after 2 wait cycles -> memByteEnable=4'b0011 held, storeComplete one cycle after memReady.
// - fetchRequest and dataRequest held continuously, MAX_DATA_STREAK=4, all zero-wait -> grant order D,D,D,D,F,D,D,D,D,F.
// - Fetch in WAIT_F, fetchFlush pulsed, memReadValid returns -> no fetchDataValid; pending dataRequest issues the following cycle.
// - reset low during WAIT_D, then memReadValid arrives -> all outputs 0, no loadDataValid, state IDLE.
// - With ARB_PERF_COUNTERS_EN: scenario 3 for 10 grants -> perfDataGrants=8, perfFetchGrants=2, perfConflictCycles=10.

Source files
------------

// File: rtl/memory_port_arbiter_if.sv
// Bundle of every handshake and bus signal of the arbiter: Fetch side, Memory-stage side and memory-macro side.
// The slave modport is the arbiter's view. The master modport is the environment's view (requesters plus memory).
// Signal names follow the arbiter's external port list; only clock and reset stay outside the bundle.
interface memory_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  // Fetch path
  logic                  fetchRequest;
  logic [ADDR_WIDTH-1:0] fetchAddress;
  logic                  fetchFlush;
  logic [31:0]           fetchData;
  logic                  fetchDataValid;
  // Memory stage
  logic                  dataRequest;
  logic                  dataWrite;
  logic [ADDR_WIDTH-1:0] dataAddress;
  logic [31:0]           dataStoreData;
  logic [3:0]            dataByteEnable;
  logic [31:0]           loadData;
  logic                  loadDataValid;
  logic                  storeComplete;
  // Memory macro
  logic                  memRequest;
  logic                  memWrite;
  logic [ADDR_WIDTH-1:0] memAddress;
  logic [31:0]           memWriteData;
  logic [3:0]            memByteEnable;
  logic                  memReady;
  logic                  memReadValid;
  logic [31:0]           memReadData;

  modport slave (
    input  fetchRequest, fetchAddress, fetchFlush,
    output fetchData, fetchDataValid,
    input  dataRequest, dataWrite, dataAddress, dataStoreData, dataByteEnable,
    output loadData, loadDataValid, storeComplete,
    output memRequest, memWrite, memAddress, memWriteData, memByteEnable,
    input  memReady, memReadValid, memReadData
  );

  modport master (
    output fetchRequest, fetchAddress, fetchFlush,
    input  fetchData, fetchDataValid,
    output dataRequest, dataWrite, dataAddress, dataStoreData, dataByteEnable,
    input  loadData, loadDataValid, storeComplete,
    input  memRequest, memWrite, memAddress, memWriteData, memByteEnable,
    output memReady, memReadValid, memReadData
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// Shares one single-ported memory between Fetch and Memory stage, one transaction at a time; data has priority, fetch wins after MAX_DATA_STREAK data grants.
// Latency: grant at edge N, memRequest from cycle N+1; response pulse one cycle after memReady (store) or memReadValid (read).
// Backpressure: memRequest and its payload hold until memReady. ARB_PERF_COUNTERS_EN adds grant and conflict counters.
module memory_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  memory_port_arbiter_if.slave    bus
`ifdef ARB_PERF_COUNTERS_EN
  ,
  output logic [31:0]             o_perfFetchGrants,
  output logic [31:0]             o_perfDataGrants,
  output logic [31:0]             o_perfConflictCycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_F,
    S_ISSUE_D,
    S_WAIT_F,
    S_WAIT_D
  } state_t;

  state_t                r_state;
  logic [3:0]            r_streak;
  logic                  r_squash;
  logic                  r_mem_req;
  logic                  r_mem_wr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdat;
  logic [3:0]            r_mem_be;
  logic [31:0]           r_fetch_dat;
  logic                  r_fetch_vld;
  logic [31:0]           r_load_dat;
  logic                  r_load_vld;
  logic                  r_store_done;

  logic w_fetch_ok;
  logic w_streak_full;
  logic w_grant_d;
  logic w_grant_f;

  // A flushed fetch is never granted. Data is refused only when fetch can be granted and the streak limit is reached.
  assign w_fetch_ok    = bus.fetchRequest && !bus.fetchFlush;
  assign w_streak_full = (r_streak == 4'(MAX_DATA_STREAK));
  assign w_grant_d     = (r_state == S_IDLE) && bus.dataRequest && !(w_fetch_ok && w_streak_full);
  assign w_grant_f     = (r_state == S_IDLE) && w_fetch_ok && !w_grant_d;

  // Arbitration FSM. All mem* and response outputs are registered here.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_streak     <= 4'd0;
      r_squash     <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdat   <= 32'd0;
      r_mem_be     <= 4'd0;
      r_fetch_dat  <= 32'd0;
      r_fetch_vld  <= 1'b0;
      r_load_dat   <= 32'd0;
      r_load_vld   <= 1'b0;
      r_store_done <= 1'b0;
    end else begin
      r_fetch_vld  <= 1'b0;
      r_load_vld   <= 1'b0;
      r_store_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_state    <= S_ISSUE_D;
            r_mem_req  <= 1'b1;
            r_mem_wr   <= bus.dataWrite;
            r_mem_addr <= bus.dataAddress;
            r_mem_wdat <= bus.dataWrite ? bus.dataStoreData : 32'd0;
            r_mem_be   <= bus.dataWrite ? bus.dataByteEnable : 4'd0;
            // The streak only counts grants that made fetch wait. It saturates at the limit.
            if (!bus.fetchRequest) begin
              r_streak <= 4'd0;
            end else if (!w_streak_full) begin
              r_streak <= r_streak + 4'd1;
            end
          end else if (w_grant_f) begin
            r_state    <= S_ISSUE_F;
            r_mem_req  <= 1'b1;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= bus.fetchAddress;
            r_mem_wdat <= 32'd0;
            r_mem_be   <= 4'd0;
            r_squash   <= 1'b0;
            r_streak   <= 4'd0;
          end
        end
        S_ISSUE_F: begin
          // An issued request is never retracted. A flush only marks the return as squashed.
          if (bus.fetchFlush) begin
            r_squash <= 1'b1;
          end
          if (bus.memReady) begin
            r_mem_req <= 1'b0;
            r_state   <= S_WAIT_F;
          end
        end
        S_ISSUE_D: begin
          if (bus.memReady) begin
            r_mem_req <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_mem_be  <= 4'd0;
            if (r_mem_wr) begin
              r_store_done <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_state <= S_WAIT_D;
            end
          end
        end
        S_WAIT_F: begin
          if (bus.memReadValid) begin
            r_state <= S_IDLE;
            if (!r_squash && !bus.fetchFlush) begin
              r_fetch_vld <= 1'b1;
              r_fetch_dat <= bus.memReadData;
            end
          end else if (bus.fetchFlush) begin
            r_squash <= 1'b1;
          end
        end
        S_WAIT_D: begin
          if (bus.memReadValid) begin
            r_load_vld <= 1'b1;
            r_load_dat <= bus.memReadData;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.memRequest     = r_mem_req;
  assign bus.memWrite       = r_mem_wr;
  assign bus.memAddress     = r_mem_addr;
  assign bus.memWriteData   = r_mem_wdat;
  assign bus.memByteEnable  = r_mem_be;
  assign bus.fetchData      = r_fetch_dat;
  assign bus.fetchDataValid = r_fetch_vld;
  assign bus.loadData       = r_load_dat;
  assign bus.loadDataValid  = r_load_vld;
  assign bus.storeComplete  = r_store_done;

`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_data;
  logic [31:0] r_perf_conflict;

  // Free-running wrap-around counters of grants and of IDLE cycles where both sides are requesting.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_perf_fetch    <= 32'd0;
      r_perf_data     <= 32'd0;
      r_perf_conflict <= 32'd0;
    end else begin
      if (w_grant_f) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (w_grant_d) begin
        r_perf_data <= r_perf_data + 32'd1;
      end
      if ((r_state == S_IDLE) && bus.fetchRequest && bus.dataRequest) begin
        r_perf_conflict <= r_perf_conflict + 32'd1;
      end
    end
  end

  assign o_perfFetchGrants    = r_perf_fetch;
  assign o_perfDataGrants     = r_perf_data;
  assign o_perfConflictCycles = r_perf_conflict;
`endif

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: requester agents, a behavioural memory, and a per-cycle scoreboard.
// Fetch addresses sit below 0x1000 and data addresses above, so every grant can be attributed to its requester.
module tb_memory_port_arbiter;
  localparam int MAX_STREAK = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_port_arbiter_if bus();

`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0] perf_f, perf_d, perf_c;
`endif

  memory_port_arbiter #(.ADDR_WIDTH(32), .MAX_DATA_STREAK(MAX_STREAK)) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus(bus)
`ifdef ARB_PERF_COUNTERS_EN
    ,
    .o_perfFetchGrants(perf_f),
    .o_perfDataGrants(perf_d),
    .o_perfConflictCycles(perf_c)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Behavioural memory: word array with a deterministic default for unwritten words.
  logic [31:0] mem [logic [29:0]];

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return {a[15:0], 16'hC0DE};
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    mem[a[31:2]] = w;
  endtask

  // Memory responder: memReady after ready_wait stall cycles, read data rv_delay cycles after acceptance.
  int ready_wait = 0;
  int rv_delay = 1;
  int wcnt = 0;
  int rv_cnt = -1;
  logic [31:0] rv_data = 32'd0;

  initial begin
    bus.memReady = 1'b0;
    bus.memReadValid = 1'b0;
    bus.memReadData = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      bus.memReadValid = 1'b0;
      if (rv_cnt == 0) begin
        bus.memReadValid = 1'b1;
        bus.memReadData = rv_data;
      end
      if (rv_cnt >= 0) rv_cnt--;
      bus.memReady = 1'b0;
      if (bus.memRequest) begin
        if (wcnt >= ready_wait) begin
          bus.memReady = 1'b1;
          wcnt = 0;
          if (bus.memWrite) mem_write(bus.memAddress, bus.memWriteData, bus.memByteEnable);
          else begin
            rv_data = rd(bus.memAddress);
            rv_cnt = rv_delay - 1;
          end
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // Requester agents: keep requesting until `done` reaches `target`, one new word address per transaction.
  int f_target = 0, f_done = 0, f_first = 0;
  int d_target = 0, d_done = 0, d_first = 0;
  logic [31:0] f_base = 32'd0, d_base = 32'd0, d_wdat = 32'd0;
  logic        d_wr = 1'b0;
  logic [3:0]  d_be = 4'd0;

  initial begin
    bus.fetchRequest = 1'b0; bus.fetchAddress = 32'd0;
    bus.dataRequest = 1'b0; bus.dataWrite = 1'b0; bus.dataAddress = 32'd0;
    bus.dataStoreData = 32'd0; bus.dataByteEnable = 4'd0;
    forever begin
      @(negedge clk);
      if (bus.fetchDataValid) f_done++;
      if (bus.loadDataValid || bus.storeComplete) d_done++;
      bus.fetchRequest   = (f_done < f_target);
      bus.fetchAddress   = f_base + 32'(4 * (f_done - f_first));
      bus.dataRequest    = (d_done < d_target);
      bus.dataWrite      = d_wr;
      bus.dataAddress    = d_base + 32'(4 * (d_done - d_first));
      bus.dataStoreData  = d_wdat;
      bus.dataByteEnable = d_be;
    end
  end

  // Scoreboard logs.
  typedef struct { int cyc; bit is_f; logic wr; logic [31:0] addr; logic [3:0] be; logic [31:0] wdat; } grant_t;
  typedef struct { int cyc; int kind; logic [31:0] data; } resp_t;  // kind: 0 fetch, 1 load, 2 store
  grant_t glog[$];
  resp_t  rlog[$];

  function automatic grant_t get_g(input int i);
    grant_t g;
    g.cyc = -1000; g.is_f = 1'b0; g.wr = 1'b0; g.addr = 32'd0; g.be = 4'd0; g.wdat = 32'd0;
    if (i < glog.size()) g = glog[i];
    return g;
  endfunction

  function automatic resp_t get_r(input int i);
    resp_t r;
    r.cyc = -1000; r.kind = -1; r.data = 32'd0;
    if (i < rlog.size()) r = rlog[i];
    return r;
  endfunction

  // Per-cycle compare: handshake rules, payload capture, and response data against the memory model.
  logic        p_req = 1'b0, p_rdy = 1'b0, p_wr = 1'b0;
  logic [31:0] p_addr = 32'd0, p_wdat = 32'd0;
  logic [3:0]  p_be = 4'd0;
  int          out_kind = -1;
  logic [31:0] out_data = 32'd0;
  int          m_np, m_k;
  logic [31:0] m_d;
  logic        m_new;

  always @(negedge clk) begin
    if (!rst_n) begin
      out_kind = -1;
      p_req = 1'b0;
      p_rdy = 1'b0;
    end else begin
      m_new = bus.memRequest && !p_req;
      m_np = int'(bus.fetchDataValid) + int'(bus.loadDataValid) + int'(bus.storeComplete);
      if (m_np != 0) begin
        m_k = bus.fetchDataValid ? 0 : (bus.loadDataValid ? 1 : 2);
        m_d = bus.fetchDataValid ? bus.fetchData : (bus.loadDataValid ? bus.loadData : 32'd0);
        chk("pulse_exclusive", m_np, 1);
        chk("pulse_not_at_grant", {31'd0, m_new}, 0);
        chk("resp_kind", m_k, out_kind);
        chk("resp_data", m_d, out_data);
        rlog.push_back('{cyc, m_k, m_d});
        out_kind = -1;
      end
      if (p_req && !p_rdy) begin
        chk("req_held", {31'd0, bus.memRequest}, 1);
        chk("addr_held", bus.memAddress, p_addr);
        chk("wr_held", {31'd0, bus.memWrite}, {31'd0, p_wr});
        chk("be_held", {28'd0, bus.memByteEnable}, {28'd0, p_be});
        chk("wdat_held", bus.memWriteData, p_wdat);
      end
      if (bus.memRequest && !bus.memWrite) chk("read_be_zero", {28'd0, bus.memByteEnable}, 0);
      if (m_new) begin
        glog.push_back('{cyc, (bus.memAddress < 32'h1000), bus.memWrite, bus.memAddress,
                        bus.memByteEnable, bus.memWriteData});
        if (bus.memAddress < 32'h1000) begin
          chk("grant_f_addr", bus.memAddress, bus.fetchAddress);
          chk("grant_f_wr", {31'd0, bus.memWrite}, 0);
        end else begin
          chk("grant_d_addr", bus.memAddress, bus.dataAddress);
          chk("grant_d_wr", {31'd0, bus.memWrite}, {31'd0, bus.dataWrite});
          if (bus.dataWrite) chk("grant_d_wdat", bus.memWriteData, bus.dataStoreData);
        end
      end
      if (bus.memRequest && bus.memReady) begin
        out_kind = (bus.memAddress < 32'h1000) ? 0 : (bus.memWrite ? 2 : 1);
        out_data = bus.memWrite ? 32'd0 : rd(bus.memAddress);
      end
      p_req = bus.memRequest; p_rdy = bus.memReady; p_wr = bus.memWrite;
      p_addr = bus.memAddress; p_wdat = bus.memWriteData; p_be = bus.memByteEnable;
    end
  end

  function automatic int nz_outputs();
    return int'(bus.memRequest) + int'(bus.memWrite) + int'(bus.memAddress != 0) +
           int'(bus.memWriteData != 0) + int'(bus.memByteEnable != 0) + int'(bus.fetchData != 0) +
           int'(bus.fetchDataValid) + int'(bus.loadData != 0) + int'(bus.loadDataValid) +
           int'(bus.storeComplete);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int s, gi, ri, nf;
  grant_t g;
  resp_t r;
  logic [9:0] ord;
`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0] pf0, pd0, pc0;
`endif

  initial begin
    bus.fetchFlush = 1'b0;
    mem[30'h40]  = 32'h0000_0013;   // 0x100
    mem[30'h801] = 32'h1122_3344;   // 0x2004
    cycles(3);
    @(negedge clk);
    chk("reset_outputs", nz_outputs(), 0);
    cycles(1);
    rst_n = 1'b1;
    cycles(2);

    // T1: lone fetch, zero-wait memory, read data one cycle after acceptance.
    ready_wait = 0; rv_delay = 1;
    s = cyc; gi = glog.size(); ri = rlog.size();
    f_base = 32'h100; f_first = f_done; f_target = f_done + 1;
    cycles(6);
    g = get_g(gi); r = get_r(ri);
    chk("t1_grant_cycle", g.cyc - s, 1);
    chk("t1_grant_addr", g.addr, 32'h100);
    chk("t1_resp_cycle", r.cyc - s, 3);
    chk("t1_resp_kind", r.kind, 0);
    chk("t1_fetch_data", r.data, 32'h0000_0013);
    chk("t1_resp_count", rlog.size() - ri, 1);

    // T2: store with two stall cycles, then a load that sees the merged lanes.
    ready_wait = 2;
    s = cyc; gi = glog.size(); ri = rlog.size();
    d_wr = 1'b1; d_base = 32'h2004; d_be = 4'b0011; d_wdat = 32'hDEAD_BEEF;
    d_first = d_done; d_target = d_done + 1;
    cycles(7);
    g = get_g(gi); r = get_r(ri);
    chk("t2_grant_cycle", g.cyc - s, 1);
    chk("t2_grant_be", {28'd0, g.be}, 32'h3);
    chk("t2_grant_wdat", g.wdat, 32'hDEAD_BEEF);
    chk("t2_store_cycle", r.cyc - s, 4);
    chk("t2_store_kind", r.kind, 2);

    ready_wait = 0; rv_delay = 2;
    s = cyc; ri = rlog.size();
    d_wr = 1'b0; d_be = 4'hF; d_first = d_done; d_target = d_done + 1;
    cycles(7);
    r = get_r(ri);
    chk("t2_load_cycle", r.cyc - s, 4);
    chk("t2_load_data", r.data, 32'h1122_BEEF);

    // T3: both sides request continuously; every (MAX_STREAK+1)-th grant goes to fetch.
    ready_wait = 0; rv_delay = 1;
    s = cyc; gi = glog.size();
`ifdef ARB_PERF_COUNTERS_EN
    pf0 = perf_f; pd0 = perf_d; pc0 = perf_c;
`endif
    f_base = 32'h400; f_first = f_done; f_target = f_done + 2;
    d_base = 32'h3000; d_first = d_done; d_target = d_done + 9;
    cycles(28);
`ifdef ARB_PERF_COUNTERS_EN
    chk("t3_perf_data", perf_d - pd0, 8);
    chk("t3_perf_fetch", perf_f - pf0, 2);
    chk("t3_perf_conflict", perf_c - pc0, 10);
`endif
    cycles(12);
    ord = 10'd0;
    for (int i = 0; i < 10; i++) begin
      g = get_g(gi + i);
      chk("t3_grant_kind", {31'd0, g.is_f}, {31'd0, ((i + 1) % (MAX_STREAK + 1)) == 0});
      chk("t3_grant_cycle", g.cyc - s, 1 + 3 * i);
      ord[i] = g.is_f;
    end
    chk("t3_order_literal", {22'd0, ord}, 32'h210);
    chk("t3_grant_count", glog.size() - gi, 11);

    // T4: flush while the fetch waits for data; the pending load issues right after the squashed return.
    ready_wait = 0; rv_delay = 3;
    s = cyc; gi = glog.size(); ri = rlog.size();
    f_base = 32'h200; f_first = f_done; f_target = f_done + 1;
    cycles(2);
    bus.fetchFlush = 1'b1;
    f_target = f_done;
    d_wr = 1'b0; d_base = 32'h2100; d_first = d_done; d_target = d_done + 1;
    cycles(1);
    bus.fetchFlush = 1'b0;
    cycles(11);
    nf = 0;
    for (int i = ri; i < rlog.size(); i++) if (rlog[i].kind == 0) nf++;
    chk("t4_no_fetch_resp", nf, 0);
    g = get_g(gi + 1);
    chk("t4_data_grant_cycle", g.cyc - s, 6);
    chk("t4_data_grant_addr", g.addr, 32'h2100);
    r = get_r(ri);
    chk("t4_load_cycle", r.cyc - s, 10);
    chk("t4_load_data", r.data, 32'h2100_C0DE);

    // T5: reset while a load waits; the late memReadValid must be ignored.
    ready_wait = 0; rv_delay = 3;
    ri = rlog.size();
    d_base = 32'h3100; d_first = d_done; d_target = d_done + 1;
    cycles(2);
    rst_n = 1'b0;
    d_target = d_done;
    cycles(1);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_outputs_zero", nz_outputs(), 0);
    end
    cycles(1);
    chk("t5_no_response", rlog.size() - ri, 0);

    // T6: zero-wait store completes in cycle 2.
    ready_wait = 0;
    s = cyc; ri = rlog.size();
    d_wr = 1'b1; d_base = 32'h2008; d_be = 4'b1100; d_wdat = 32'hCAFE_F00D;
    d_first = d_done; d_target = d_done + 1;
    cycles(5);
    r = get_r(ri);
    chk("t6_store_cycle", r.cyc - s, 2);
    chk("t6_store_kind", r.kind, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
